// File: rtl/core_pkg.sv
// core_pkg: shared core types, including the memory arbiter's requester, state and request types.
package core_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic {MEM_REQUESTER_IF, MEM_REQUESTER_LS} mem_requester_e;
  typedef enum logic [1:0] {MEM_ARB_IDLE, MEM_ARB_REQ, MEM_ARB_RSP} mem_arb_state_e;
  typedef struct packed {
    word_t      addr;
    word_t      wdata;
    logic       wen;
    logic [3:0] wmask;
  } mem_req_s;
endpackage

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory bus port between fetch and load/store, one transaction in flight.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_if_req_valid,
  output logic       o_if_req_ready,
  input  word_t      i_if_req_addr,
  output logic       o_if_rsp_valid,
  output word_t      o_if_rsp_rdata,
  output logic       o_if_rsp_err,
  input  logic       i_ls_req_valid,
  output logic       o_ls_req_ready,
  input  word_t      i_ls_req_addr,
  input  word_t      i_ls_req_wdata,
  input  logic       i_ls_req_wen,
  input  logic [3:0] i_ls_req_wmask,
  output logic       o_ls_rsp_valid,
  output word_t      o_ls_rsp_rdata,
  output logic       o_ls_rsp_err,
  output logic       o_bus_req_valid,
  input  logic       i_bus_req_ready,
  output word_t      o_bus_req_addr,
  output word_t      o_bus_req_wdata,
  output logic       o_bus_req_wen,
  output logic [3:0] o_bus_req_wmask,
  input  logic       i_bus_rsp_valid,
  input  word_t      i_bus_rsp_rdata,
  input  logic       i_bus_rsp_err
);
  localparam int unsigned SW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  mem_arb_state_e state_q, state_d;
  mem_requester_e owner_q, owner_d;
  logic [SW-1:0]  starve_q, starve_d;
  mem_req_s       req_q, req_d;
  logic           bus_valid_q;
  logic           idle, ls_win, rsp_hit;
  always_comb begin
    idle           = state_q == MEM_ARB_IDLE;
    // LS takes ties until IF has been passed over LIMIT times in a row
    ls_win         = i_ls_req_valid & ~(i_if_req_valid & (starve_q >= LIMIT));
    o_ls_req_ready = idle & ls_win;
    o_if_req_ready = idle & i_if_req_valid & ~ls_win;
    rsp_hit        = (state_q == MEM_ARB_RSP) & i_bus_rsp_valid;
    state_d  = (o_if_req_ready | o_ls_req_ready)            ? MEM_ARB_REQ  :
               (state_q == MEM_ARB_REQ) & i_bus_req_ready   ? MEM_ARB_RSP  :
               rsp_hit                                      ? MEM_ARB_IDLE : state_q;
    owner_d  = o_ls_req_ready ? MEM_REQUESTER_LS : o_if_req_ready ? MEM_REQUESTER_IF : owner_q;
    starve_d = o_if_req_ready ? '0 :
               (o_ls_req_ready & i_if_req_valid & (starve_q < LIMIT)) ? starve_q + SW'(1) : starve_q;
    req_d    = o_ls_req_ready ? mem_req_s'{addr: i_ls_req_addr, wdata: i_ls_req_wdata,
                                           wen: i_ls_req_wen, wmask: i_ls_req_wmask} :
               o_if_req_ready ? mem_req_s'{addr: i_if_req_addr, wdata: '0, wen: 1'b0, wmask: 4'hf} :
               req_q;
    o_if_rsp_valid = rsp_hit & (owner_q == MEM_REQUESTER_IF);
    o_ls_rsp_valid = rsp_hit & (owner_q == MEM_REQUESTER_LS);
    o_if_rsp_rdata = o_if_rsp_valid ? i_bus_rsp_rdata : '0;
    o_ls_rsp_rdata = o_ls_rsp_valid ? i_bus_rsp_rdata : '0;
    o_if_rsp_err   = o_if_rsp_valid & i_bus_rsp_err;
    o_ls_rsp_err   = o_ls_rsp_valid & i_bus_rsp_err;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= MEM_ARB_IDLE;
      owner_q     <= MEM_REQUESTER_IF;
      starve_q    <= '0;
      req_q       <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      req_q       <= req_d;
      bus_valid_q <= state_d == MEM_ARB_REQ;
    end
  end
  assign o_bus_req_valid = bus_valid_q;
  assign o_bus_req_addr  = req_q.addr;
  assign o_bus_req_wdata = req_q.wdata;
  assign o_bus_req_wen   = req_q.wen;
  assign o_bus_req_wmask = req_q.wmask;
  // A response outside RSP has no owner; it is dropped and reported here.
  a_rsp_only_in_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_bus_rsp_valid |-> state_q == MEM_ARB_RSP)
    else $warning("bus response outside RSP ignored");
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed checks of arbitration, stalls, responses and reset for core_mem_arbiter.
module tb_core_mem_arbiter;
  import core_pkg::*;
  logic clk = 0, rst_n = 0;
  logic if_valid = 0, ls_valid = 0, ls_wen = 0;
  word_t if_addr = '0, ls_addr = '0, ls_wdata = '0, bus_rdata = '0;
  logic [3:0] ls_wmask = '0;
  logic bus_ready = 1, bus_err = 0, rsp_en = 1, spur = 0, pend, pend0;
  logic if_ready, ls_ready, if_rsp_valid, if_rsp_err, ls_rsp_valid, ls_rsp_err;
  word_t if_rsp_rdata, ls_rsp_rdata, bus_addr, bus_wdata;
  logic bus_valid, bus_wen;
  logic [3:0] bus_wmask;
  logic if_ready0, ls_ready0, if_rsp_valid0, if_rsp_err0, ls_rsp_valid0, ls_rsp_err0, bus_valid0, bus_wen0;
  word_t if_rsp_rdata0, ls_rsp_rdata0, bus_addr0, bus_wdata0;
  logic [3:0] bus_wmask0;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  // Bench bus models: answer one cycle after the request handshake.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin pend <= 0; pend0 <= 0; end
    else begin
      pend  <= rsp_en & bus_valid & bus_ready;
      pend0 <= bus_valid0;
    end

  core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req_valid(if_valid), .o_if_req_ready(if_ready), .i_if_req_addr(if_addr),
    .o_if_rsp_valid(if_rsp_valid), .o_if_rsp_rdata(if_rsp_rdata), .o_if_rsp_err(if_rsp_err),
    .i_ls_req_valid(ls_valid), .o_ls_req_ready(ls_ready), .i_ls_req_addr(ls_addr),
    .i_ls_req_wdata(ls_wdata), .i_ls_req_wen(ls_wen), .i_ls_req_wmask(ls_wmask),
    .o_ls_rsp_valid(ls_rsp_valid), .o_ls_rsp_rdata(ls_rsp_rdata), .o_ls_rsp_err(ls_rsp_err),
    .o_bus_req_valid(bus_valid), .i_bus_req_ready(bus_ready), .o_bus_req_addr(bus_addr),
    .o_bus_req_wdata(bus_wdata), .o_bus_req_wen(bus_wen), .o_bus_req_wmask(bus_wmask),
    .i_bus_rsp_valid(pend | spur), .i_bus_rsp_rdata(bus_rdata), .i_bus_rsp_err(bus_err));

  core_mem_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req_valid(if_valid), .o_if_req_ready(if_ready0), .i_if_req_addr(if_addr),
    .o_if_rsp_valid(if_rsp_valid0), .o_if_rsp_rdata(if_rsp_rdata0), .o_if_rsp_err(if_rsp_err0),
    .i_ls_req_valid(ls_valid), .o_ls_req_ready(ls_ready0), .i_ls_req_addr(ls_addr),
    .i_ls_req_wdata(ls_wdata), .i_ls_req_wen(ls_wen), .i_ls_req_wmask(ls_wmask),
    .o_ls_rsp_valid(ls_rsp_valid0), .o_ls_rsp_rdata(ls_rsp_rdata0), .o_ls_rsp_err(ls_rsp_err0),
    .o_bus_req_valid(bus_valid0), .i_bus_req_ready(1'b1), .o_bus_req_addr(bus_addr0),
    .o_bus_req_wdata(bus_wdata0), .o_bus_req_wen(bus_wen0), .o_bus_req_wmask(bus_wmask0),
    .i_bus_rsp_valid(pend0), .i_bus_rsp_rdata(bus_rdata), .i_bus_rsp_err(1'b0));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (bus_valid !== 1'b0) begin $display("FAIL reset_bus_valid: got %b want 0", bus_valid); n_bad++; end
    n_vec++; if ({bus_addr, bus_wdata, bus_wen, bus_wmask} !== 69'd0) begin $display("FAIL reset_bus_payload: got %h want 0", {bus_addr, bus_wdata, bus_wen, bus_wmask}); n_bad++; end
    n_vec++; if ({if_ready, ls_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err} !== 6'd0) begin $display("FAIL reset_ctrl: got %b want 000000", {if_ready, ls_ready, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err}); n_bad++; end
    n_vec++; if ({if_rsp_rdata, ls_rsp_rdata} !== 64'd0) begin $display("FAIL reset_rdata: got %h want 0", {if_rsp_rdata, ls_rsp_rdata}); n_bad++; end
    tick(); rst_n = 1;
  endtask

  task automatic test_if_only();
    tick(); if_valid = 1; if_addr = 32'h0000_1000; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++; if ({if_ready, ls_ready} !== 2'b10) begin $display("FAIL if_grant: got %b want 10", {if_ready, ls_ready}); n_bad++; end
    tick(); if_valid = 0;
    @(negedge clk);
    n_vec++; if ({bus_valid, bus_addr, bus_wen, bus_wmask, bus_wdata} !== {1'b1, 32'h1000, 1'b0, 4'hf, 32'h0}) begin $display("FAIL if_bus_req: got %h want %h", {bus_valid, bus_addr, bus_wen, bus_wmask, bus_wdata}, {1'b1, 32'h1000, 1'b0, 4'hf, 32'h0}); n_bad++; end
    @(negedge clk);
    n_vec++; if ({bus_valid, if_rsp_valid, if_rsp_rdata} !== {2'b01, 32'hDEADBEEF}) begin $display("FAIL if_rsp: got %h want %h", {bus_valid, if_rsp_valid, if_rsp_rdata}, {2'b01, 32'hDEADBEEF}); n_bad++; end
    n_vec++; if ({ls_rsp_valid, ls_rsp_rdata} !== 33'd0) begin $display("FAIL if_rsp_ls_quiet: got %h want 0", {ls_rsp_valid, ls_rsp_rdata}); n_bad++; end
    tick();
  endtask

  task automatic test_priority();
    logic [5:0] got = '0;
    int g = 0;
    tick(); if_valid = 1; ls_valid = 1; if_addr = 32'h100; ls_addr = 32'h200; ls_wen = 0; ls_wmask = 4'hf;
    for (int c = 0; c < 80 && g < 6; c++) begin
      @(negedge clk);
      if (if_ready && ls_ready) begin n_vec++; n_bad++; $display("FAIL prio_both_ready: got 11 want one-hot"); end
      if (if_ready || ls_ready) begin got[5 - g] = ls_ready; g++; end
    end
    tick(); if_valid = 0; ls_valid = 0;
    n_vec++; if (g !== 6) begin $display("FAIL prio_grant_count: got %0d want 6", g); n_bad++; end
    n_vec++; if (got !== 6'b111101) begin $display("FAIL prio_order (1=LS): got %b want 111101", got); n_bad++; end
    repeat (3) tick();
  endtask

  task automatic test_ls_store();
    tick(); bus_ready = 0; bus_err = 1; bus_rdata = 32'h0;
    ls_valid = 1; ls_addr = 32'h2004; ls_wdata = 32'h12345678; ls_wen = 1; ls_wmask = 4'b0011;
    @(negedge clk);
    n_vec++; if ({if_ready, ls_ready} !== 2'b01) begin $display("FAIL ls_grant: got %b want 01", {if_ready, ls_ready}); n_bad++; end
    tick(); ls_valid = 0; if_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if ({bus_valid, bus_addr, bus_wdata, bus_wen, bus_wmask} !== {1'b1, 32'h2004, 32'h12345678, 1'b1, 4'b0011}) begin $display("FAIL ls_stall_payload[%0d]: got %h want %h", i, {bus_valid, bus_addr, bus_wdata, bus_wen, bus_wmask}, {1'b1, 32'h2004, 32'h12345678, 1'b1, 4'b0011}); n_bad++; end
      n_vec++; if ({if_ready, ls_ready} !== 2'b00) begin $display("FAIL ls_stall_ready[%0d]: got %b want 00", i, {if_ready, ls_ready}); n_bad++; end
    end
    bus_ready = 1; if_valid = 0;
    @(negedge clk);
    n_vec++; if ({bus_valid, ls_rsp_valid, ls_rsp_err, if_rsp_valid, if_rsp_err} !== 5'b01100) begin $display("FAIL ls_rsp_err: got %b want 01100", {bus_valid, ls_rsp_valid, ls_rsp_err, if_rsp_valid, if_rsp_err}); n_bad++; end
    tick(); bus_err = 0;
  endtask

  task automatic test_reset_mid();
    tick(); rsp_en = 0; if_valid = 1; if_addr = 32'h3000;
    tick(); if_valid = 0;
    @(negedge clk);
    n_vec++; if ({bus_valid, bus_addr} !== {1'b1, 32'h3000}) begin $display("FAIL mid_req: got %h want %h", {bus_valid, bus_addr}, {1'b1, 32'h3000}); n_bad++; end
    repeat (2) @(negedge clk);
    #2 rst_n = 0; #1;
    n_vec++; if ({bus_valid, bus_addr, bus_wmask, if_rsp_valid, ls_rsp_valid, if_ready, ls_ready} !== 41'd0) begin $display("FAIL mid_reset_outputs: got %h want 0", {bus_valid, bus_addr, bus_wmask, if_rsp_valid, ls_rsp_valid, if_ready, ls_ready}); n_bad++; end
    tick(); rst_n = 1; rsp_en = 1;
    @(negedge clk); spur = 1; bus_rdata = 32'hAAAA5555; #1;
    n_vec++; if ({if_rsp_valid, ls_rsp_valid, if_rsp_rdata} !== 34'd0) begin $display("FAIL late_rsp_ignored: got %h want 0", {if_rsp_valid, ls_rsp_valid, if_rsp_rdata}); n_bad++; end
    tick(); spur = 0;
  endtask

  task automatic test_spurious_idle();
    @(negedge clk); spur = 1; bus_rdata = 32'h55AA55AA; #1;
    n_vec++; if ({if_rsp_valid, ls_rsp_valid, bus_valid} !== 3'b000) begin $display("FAIL spur_no_pulse: got %b want 000", {if_rsp_valid, ls_rsp_valid, bus_valid}); n_bad++; end
    tick(); spur = 0; if_valid = 1; if_addr = 32'h4000;
    @(negedge clk);
    n_vec++; if ({if_ready, bus_valid} !== 2'b10) begin $display("FAIL spur_still_idle: got %b want 10", {if_ready, bus_valid}); n_bad++; end
    tick(); if_valid = 0;
    @(negedge clk);
    n_vec++; if ({bus_valid, bus_addr} !== {1'b1, 32'h4000}) begin $display("FAIL spur_next_req: got %h want %h", {bus_valid, bus_addr}, {1'b1, 32'h4000}); n_bad++; end
    repeat (3) tick();
  endtask

  task automatic test_starve_zero();
    int g = 0;
    tick(); if_valid = 1; ls_valid = 1; if_addr = 32'h500; ls_addr = 32'h600; ls_wen = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (if_ready0 || ls_ready0) begin
        n_vec++; if ({if_ready0, ls_ready0} !== 2'b10) begin $display("FAIL starve0_grant[%0d]: got %b want 10", g, {if_ready0, ls_ready0}); n_bad++; end
        g++;
      end
    end
    tick(); if_valid = 0; ls_valid = 0;
    n_vec++; if (g !== 4) begin $display("FAIL starve0_count: got %0d want 4", g); n_bad++; end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_priority();
    test_ls_store();
    test_reset_mid();
    test_spurious_idle();
    test_starve_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
